adder_frame_accumulator: RTL and testbench

Downstream consumer of the 8-bit full adder's result (`S`, `cout`). Each 9-bit result `{cout,S}` is accepted over a valid/ready handshake and summed into a saturating accumulator. After `N_SAMPLES` accepted results, the frame total is presented on an output valid/ready handshake. Typical uses are averaging adder outputs and checksum-style reduction of operand streams.

---
 rtl/adder_frame_accumulator_if.sv | 25 ++
 rtl/adder_frame_accumulator.sv | 79 +++++++
 tb/tb_adder_frame_accumulator.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_frame_accumulator_if.sv
// rtl/adder_frame_accumulator_if.sv - result-in / frame-out handshake bundle for adder_frame_accumulator
interface adder_frame_accumulator_if #(
   parameter int ACC_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       S;
   logic             cout;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] acc_out;
   logic             ovf;
   logic [7:0]       count;

   modport master (
      output in_valid, S, cout, flush, out_ready,
      input  in_ready, out_valid, acc_out, ovf, count
   );

   modport slave (
      input  in_valid, S, cout, flush, out_ready,
      output in_ready, out_valid, acc_out, ovf, count
   );
endinterface

// File: rtl/adder_frame_accumulator.sv
// rtl/adder_frame_accumulator.sv - saturating frame accumulator of 9-bit adder results {cout,S}
module adder_frame_accumulator #(
   parameter int N_SAMPLES = 4,
   parameter int ACC_W     = 16
) (
   input logic                      clk,
   input logic                      rst,
   adder_frame_accumulator_if.slave bus
);
   typedef enum logic {ACC, DONE} state_t;

   localparam logic [7:0]       LAST    = 8'(N_SAMPLES);
   localparam logic [ACC_W-1:0] ACC_MAX = '1;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [7:0]       count_q, count_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W:0]   sample;
   logic [ACC_W:0]   sum;

   // One extra bit on the adder makes the saturation test exact.
   assign sample = {{(ACC_W-8){1'b0}}, bus.cout, bus.S};
   assign sum    = {1'b0, acc_q} + sample;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACC;
         acc_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      count_d       = count_q;
      ovf_d         = ovf_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state_q)
         ACC: begin
            bus.in_ready = !bus.flush && !rst;
            if (bus.flush) begin
               acc_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
            end else if (bus.in_valid) begin
               acc_d   = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
               ovf_d   = ovf_q | sum[ACC_W];
               count_d = count_q + 8'd1;
               if (count_d == LAST) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            // A completed frame is held until taken; flush cannot discard it.
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               acc_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
               state_d = ACC;
            end
         end
      endcase
   end

   assign bus.acc_out = acc_q;
   assign bus.ovf     = ovf_q;
   assign bus.count   = count_q;
endmodule

// File: tb/tb_adder_frame_accumulator.sv
// tb/tb_adder_frame_accumulator.sv - directed scoreboard bench for adder_frame_accumulator
module tb_adder_frame_accumulator;
   typedef struct {
      logic [31:0] acc;
      logic        ovf;
   } frame_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          vectors = 0;
   int          miscompares = 0;
   frame_t      q0[$];
   frame_t      q1[$];
   logic [31:0] m_acc[2];
   logic        m_ovf[2];
   int          m_cnt[2];

   always #5 clk = ~clk;

   adder_frame_accumulator_if #(.ACC_W(16)) b0 ();
   adder_frame_accumulator_if #(.ACC_W(10)) b1 ();

   adder_frame_accumulator #(.N_SAMPLES(4), .ACC_W(16)) d0 (.clk(clk), .rst(rst), .bus(b0));
   adder_frame_accumulator #(.N_SAMPLES(4), .ACC_W(10)) d1 (.clk(clk), .rst(rst), .bus(b1));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] acc_max(input int which);
      return (which == 1) ? 32'h3FF : 32'hFFFF;
   endfunction

   task automatic clear_model(input int which);
      m_acc[which] = '0;
      m_ovf[which] = 1'b0;
      m_cnt[which] = 0;
   endtask

   task automatic push(input int which, input logic [8:0] v);
      logic [32:0] s;
      frame_t      f;
      if (which == 0) begin
         b0.in_valid = 1'b1;
         {b0.cout, b0.S} = v;
         #1 check("accept_in_ready", b0.in_ready, 1);
      end else begin
         b1.in_valid = 1'b1;
         {b1.cout, b1.S} = v;
         #1 check("accept_in_ready", b1.in_ready, 1);
      end
      s = {1'b0, m_acc[which]} + 33'(v);
      if (s > 33'(acc_max(which))) begin
         m_acc[which] = acc_max(which);
         m_ovf[which] = 1'b1;
      end else begin
         m_acc[which] = s[31:0];
      end
      m_cnt[which]++;
      if (m_cnt[which] == 4) begin
         f.acc = m_acc[which];
         f.ovf = m_ovf[which];
         if (which == 0) q0.push_back(f);
         else q1.push_back(f);
         clear_model(which);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int which);
      if (which == 0) b0.in_valid = 1'b0;
      else b1.in_valid = 1'b0;
   endtask

   task automatic bubble0();
      b0.in_valid = 1'b0;
      {b0.cout, b0.S} = 9'($urandom);
      #1 check("bubble_count", b0.count, m_cnt[0]);
      @(negedge clk);
   endtask

   task automatic wait_frame(input int which, input string tag, input int lat);
      int     n = 0;
      int     qs;
      frame_t f;
      logic   ov;
      ov = (which == 0) ? b0.out_valid : b1.out_valid;
      while (ov !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
         ov = (which == 0) ? b0.out_valid : b1.out_valid;
      end
      check({tag, "_latency"}, n, lat);
      qs = (which == 0) ? q0.size() : q1.size();
      check({tag, "_sb_depth"}, qs, 1);
      if (n < 20 && qs > 0) begin
         if (which == 0) begin
            f = q0.pop_front();
            check({tag, "_acc"}, b0.acc_out, f.acc);
            check({tag, "_ovf"}, b0.ovf, f.ovf);
            check({tag, "_count"}, b0.count, 4);
            check({tag, "_in_ready"}, b0.in_ready, 0);
         end else begin
            f = q1.pop_front();
            check({tag, "_acc"}, b1.acc_out, f.acc);
            check({tag, "_ovf"}, b1.ovf, f.ovf);
            check({tag, "_count"}, b1.count, 4);
            check({tag, "_in_ready"}, b1.in_ready, 0);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      b0.in_valid = 0; b0.S = 0; b0.cout = 0; b0.flush = 0; b0.out_ready = 1;
      b1.in_valid = 0; b1.S = 0; b1.cout = 0; b1.flush = 0; b1.out_ready = 1;
      clear_model(0);
      clear_model(1);

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready", b0.in_ready, 0);
      check("rst_out_valid", b0.out_valid, 0);
      check("rst_acc", b0.acc_out, 0);
      check("rst_count", b0.count, 0);
      check("rst_ovf", b0.ovf, 0);
      rst = 0;
      #1 check("post_rst_in_ready", b0.in_ready, 1);
      @(negedge clk);

      // Nominal frame
      push(0, 9'h10D); push(0, 9'h110); push(0, 9'h198); push(0, 9'h1FF);
      idle(0);
      wait_frame(0, "nominal", 0);
      check("nominal_total", b0.acc_out, 32'h05B4);
      @(negedge clk);
      check("nominal_one_cycle", b0.out_valid, 0);
      check("nominal_in_ready_back", b0.in_ready, 1);

      // Backpressure
      b0.out_ready = 0;
      push(0, 9'h10D); push(0, 9'h110); push(0, 9'h198); push(0, 9'h1FF);
      idle(0);
      wait_frame(0, "bp", 0);
      for (int i = 0; i < 5; i++) begin
         b0.in_valid = 1'b1;
         {b0.cout, b0.S} = 9'h0FF;
         #1;
         check("bp_out_valid", b0.out_valid, 1);
         check("bp_acc_hold", b0.acc_out, 32'h05B4);
         check("bp_in_ready", b0.in_ready, 0);
         check("bp_count_hold", b0.count, 4);
         @(negedge clk);
      end
      b0.in_valid = 1'b0;
      b0.out_ready = 1'b1;
      #1;
      check("bp_last_valid", b0.out_valid, 1);
      check("bp_last_acc", b0.acc_out, 32'h05B4);
      @(negedge clk);
      check("bp_released", b0.out_valid, 0);
      check("bp_acc_cleared", b0.acc_out, 0);
      check("bp_count_cleared", b0.count, 0);
      push(0, 9'h001); push(0, 9'h001); push(0, 9'h001); push(0, 9'h001);
      idle(0);
      wait_frame(0, "bp_next", 0);
      @(negedge clk);

      // Saturation on the 10-bit instance
      push(1, 9'h1FF); push(1, 9'h1FF); push(1, 9'h1FF);
      check("sat_acc_after3", b1.acc_out, 32'h3FF);
      check("sat_ovf_after3", b1.ovf, 1);
      push(1, 9'h1FF);
      idle(1);
      wait_frame(1, "sat", 0);
      check("sat_frame_ovf", b1.ovf, 1);
      @(negedge clk);
      push(1, 9'h001); push(1, 9'h001); push(1, 9'h001); push(1, 9'h001);
      idle(1);
      wait_frame(1, "sat_next", 0);
      check("sat_next_total", b1.acc_out, 32'h004);
      @(negedge clk);

      // Flush
      push(0, 9'h10D); push(0, 9'h110);
      b0.in_valid = 1'b1;
      {b0.cout, b0.S} = 9'h198;
      b0.flush = 1'b1;
      #1 check("flush_in_ready", b0.in_ready, 0);
      @(negedge clk);
      b0.flush = 1'b0;
      b0.in_valid = 1'b0;
      clear_model(0);
      #1;
      check("flush_count", b0.count, 0);
      check("flush_acc", b0.acc_out, 0);
      @(negedge clk);
      push(0, 9'h001); push(0, 9'h001); push(0, 9'h001); push(0, 9'h001);
      idle(0);
      wait_frame(0, "flush_next", 0);
      check("flush_next_total", b0.acc_out, 32'h0004);
      @(negedge clk);

      // Bubbles
      for (int i = 0; i < 4; i++) begin
         push(0, 9'h010);
         if (i < 3) bubble0();
      end
      idle(0);
      wait_frame(0, "bubble", 0);
      check("bubble_total", b0.acc_out, 32'h0040);
      @(negedge clk);

      // Random operands
      for (int i = 0; i < 4; i++) push(0, 9'($urandom_range(0, 511)));
      idle(0);
      wait_frame(0, "random", 0);
      @(negedge clk);

      // Reset while DONE is stalled
      b0.out_ready = 0;
      push(0, 9'h1FF); push(0, 9'h1FF); push(0, 9'h1FF); push(0, 9'h1FF);
      idle(0);
      wait_frame(0, "pre_rst", 0);
      rst = 1;
      @(negedge clk);
      check("rst_done_out_valid", b0.out_valid, 0);
      check("rst_done_count", b0.count, 0);
      check("rst_done_acc", b0.acc_out, 0);
      check("rst_done_ovf", b0.ovf, 0);
      check("rst_done_in_ready", b0.in_ready, 0);
      rst = 0;
      b0.out_ready = 1;
      #1 check("rst_done_in_ready_after", b0.in_ready, 1);
      @(negedge clk);

      // Reset after two accepts
      push(0, 9'h1FF); push(0, 9'h1FF);
      b0.in_valid = 1'b0;
      rst = 1;
      @(negedge clk);
      check("rst_mid_count", b0.count, 0);
      check("rst_mid_acc", b0.acc_out, 0);
      rst = 0;
      clear_model(0);
      #1 check("rst_mid_in_ready_after", b0.in_ready, 1);
      @(negedge clk);
      push(0, 9'h020); push(0, 9'h020); push(0, 9'h020); push(0, 9'h020);
      idle(0);
      wait_frame(0, "post_rst", 0);
      check("post_rst_total", b0.acc_out, 32'h0080);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
